udma_event_collector: RTL and testbench
=======================================

UDMA_EVENT_COLLECTOR -- requirements
Module: udma_event_collector

Interface
REQ-001 SHALL have parameter NB_EVT, default 128: number of event lines from the uDMA subsystem events_o bus.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: event-ID queue depth (power of two, >=2).
REQ-003 SHALL have one clock and a synchronous, active-high reset, both listed below.
REQ-004 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 evt_i  in  NB_EVT  event pulses from udma_subsystem events_o; any number high in one cycle.
REQ-007 mask_i  in  NB_EVT  1 = line ignored.
REQ-008 evt_valid_o  out  1  queue head valid.
REQ-009 evt_id_o  out  $clog2(NB_EVT)  event index at queue head.
REQ-010 evt_ready_i  in  1  consumer accepts head.
REQ-011 fifo_cnt_o  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-012 lost_cnt_o  out  16  count of dropped events, saturating.
REQ-013 lost_clr_i  in  1  clear lost_cnt_o.

Function
REQ-014 SHALL keep a pending register, one bit per line; pending[i] is set at the edge where evt_i[i]=1 and mask_i[i]=0.
REQ-015 SHALL select each cycle the lowest-index set pending bit; if the queue accepts a push that cycle, it SHALL push that index and clear that pending bit at the same edge.
REQ-016 Queue accepts a push when fifo_cnt_o<FIFO_DEPTH, or when fifo_cnt_o==FIFO_DEPTH and a pop occurs the same cycle.
REQ-017 Pop SHALL occur on evt_valid_o & evt_ready_i; evt_valid_o = (fifo_cnt_o!=0); evt_id_o SHALL be the oldest entry and stay stable while valid and not popped.
REQ-018 Latency: pulse sampled at edge E with empty pending and non-full queue -> evt_valid_o=1 with that index after edge E+1 (2 cycles).
REQ-019 Set/clear collision: if pending[i] is being pushed and evt_i[i]=1 the same cycle, pending[i] SHALL remain 1 (new occurrence kept, not lost).
REQ-020 Loss: evt_i[i]=1, unmasked, pending[i]=1 and not pushed that cycle -> one lost event per such line; lost_cnt_o SHALL add the number of lost lines that cycle, saturating at 16'hFFFF.
REQ-021 lost_clr_i=1 SHALL load lost_cnt_o with the lost count of that same cycle (clear wins over old value, not over new losses).
REQ-022 Simultaneous push and pop SHALL leave fifo_cnt_o unchanged; read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 Masking a line SHALL NOT clear an already-set pending bit; it only blocks new sets.
REQ-024 Full queue: pending bits SHALL hold until space frees; no entry is overwritten.

Reset
REQ-025 rst_i=1 at an edge SHALL clear pending, FIFO pointers, fifo_cnt_o and lost_cnt_o; evt_valid_o=0 and evt_id_o=0 the cycle after.
REQ-026 Reset mid-operation SHALL discard queued and pending events without counting them as lost; evt_i during reset is ignored.

Structure
REQ-027 Package udma_evt_pkg SHALL hold NB_EVT_DEF=128, FIFO_DEPTH_DEF=8, LOST_CNT_W=16 and the evt_id_t typedef.
REQ-028 Queue SHALL be a sub-module udma_evt_fifo (push/pop, data, count, full/empty), parameterised by depth and width.
REQ-029 Pending-select SHALL be a combinational lowest-index priority encoder inside udma_event_collector.

Verification
REQ-030 Single pulse evt_i[5] at edge E, ready=1 -> evt_valid_o=1, evt_id_o=5 after E+1, one cycle only; lost_cnt_o=0.
REQ-031 evt_i[3], [64], [127] in one cycle, ready=1 -> IDs 3, 64, 127 on consecutive cycles.
REQ-032 ready=0, pulse lines 0..9 one per cycle -> fifo_cnt_o saturates at 8, pending holds 8 and 9; ready=1 -> IDs 0..9 in order, lost_cnt_o=0.
REQ-033 ready=0, queue full, evt_i[2] pulsed 3 times -> lost_cnt_o=2; lost_clr_i -> 0.
REQ-034 mask_i[7]=1, pulse evt_i[7] -> no output; pending set earlier for 7 still delivered.
REQ-035 rst_i asserted with 4 queued and 2 pending -> evt_valid_o=0, fifo_cnt_o=0, lost_cnt_o=0 next cycle; no stale IDs afterwards.

Source files
------------

// File: rtl/udma_evt_pkg.sv
// Shared definitions for the uDMA event collector.
// Holds the default geometry of the collector (number of event lines and
// queue depth), the width of the saturating lost-event counter, the event
// index type and a saturating-add helper used by the lost counter.
package udma_evt_pkg;

    localparam int NB_EVT_DEF     = 128;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int LOST_CNT_W     = 16;

    typedef logic [$clog2(NB_EVT_DEF)-1:0] evt_id_t;

    // Adds two counter values and clamps at all-ones instead of wrapping.
    function automatic logic [LOST_CNT_W-1:0] satAdd(
        input logic [LOST_CNT_W-1:0] a,
        input logic [LOST_CNT_W-1:0] b
    );
        logic [LOST_CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[LOST_CNT_W] ? '1 : sum[LOST_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/udma_evt_fifo.sv
// Event-ID queue used by the uDMA event collector.
// Ports:
//   clk_i, rst_i   clock and synchronous active-high reset
//   push_i/data_i  write request and the entry to store
//   pop_i          remove the oldest entry
//   data_o         oldest entry (forced to zero while empty)
//   cnt_o          current occupancy, 0..DEPTH
//   full_o/empty_o occupancy flags
// A push against a full queue is accepted only when a pop happens in the
// same cycle, so an entry is never overwritten.
module udma_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   cnt_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pushOk, popOk;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign cnt_o   = cnt_q;
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

    assign popOk  = pop_i & ~empty_o;
    assign pushOk = push_i & (~full_o | popOk);

    // Pointers are exactly PTR_W bits wide, so DEPTH being a power of two
    // makes the increment wrap modulo DEPTH for free.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        cnt_d   = cnt_q;
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        case ({pushOk, popOk})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; reset empties the queue without touching storage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            cnt_q   <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: stale contents are hidden by data_o gating.
    always_ff @(posedge clk_i) begin
        if (!rst_i && pushOk) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/udma_event_collector.sv
// Collects single-cycle event pulses from the uDMA subsystem and serialises
// them into a queue of event indices.
// Ports:
//   clk_i, rst_i         clock and synchronous active-high reset
//   evt_i, mask_i        event pulses and per-line ignore mask
//   evt_valid_o/evt_id_o queue head (valid/index)
//   evt_ready_i          consumer takes the head
//   fifo_cnt_o           queue occupancy
//   lost_cnt_o           saturating count of dropped events
//   lost_clr_i           reload the lost counter with this cycle's losses
// Each line has a pending bit; one pending line (lowest index first) moves
// into the queue per cycle. A pulse on a line that is still pending and not
// leaving this cycle is counted as lost.
module udma_event_collector
    import udma_evt_pkg::*;
#(
    parameter int NB_EVT     = NB_EVT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NB_EVT-1:0]             evt_i,
    input  logic [NB_EVT-1:0]             mask_i,
    output logic                          evt_valid_o,
    output logic [$clog2(NB_EVT)-1:0]     evt_id_o,
    input  logic                          evt_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
    output logic [LOST_CNT_W-1:0]         lost_cnt_o,
    input  logic                          lost_clr_i
);

    localparam int ID_W   = $clog2(NB_EVT);
    localparam int LOSS_W = $clog2(NB_EVT + 1);

    logic [NB_EVT-1:0]     pending_q, pending_d;
    logic [LOST_CNT_W-1:0] lostCnt_q, lostCnt_d;
    logic [NB_EVT-1:0]     setMask, pushMask, lostMask;
    logic [ID_W-1:0]       selId;
    logic                  selValid;
    logic                  pushEn, popEn;
    logic                  fifoFull, fifoEmpty;
    logic [LOSS_W-1:0]     lostNum;

    // Lowest-index priority encoder: scanning downwards lets the last hit,
    // i.e. the lowest set index, win.
    always_comb begin
        selValid = 1'b0;
        selId    = '0;
        for (int i = NB_EVT - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                selValid = 1'b1;
                selId    = ID_W'(i);
            end
        end
    end

    assign evt_valid_o = ~fifoEmpty;
    assign popEn       = evt_valid_o & evt_ready_i;
    assign pushEn      = selValid & (~fifoFull | popEn);

    // One-hot of the line leaving pending this cycle.
    always_comb begin
        pushMask = '0;
        if (pushEn) begin
            pushMask[selId] = 1'b1;
        end
    end

    // A fresh pulse re-sets a line even as it is pushed, so a collision keeps
    // the new occurrence; masking never clears a bit that is already set.
    assign setMask   = evt_i & ~mask_i;
    assign lostMask  = setMask & pending_q & ~pushMask;
    assign pending_d = (pending_q & ~pushMask) | setMask;

    // Number of lines dropping an event this cycle, folded into the counter.
    // Clear only discards the old total; this cycle's losses still count.
    always_comb begin
        lostNum = '0;
        for (int i = 0; i < NB_EVT; i++) begin
            lostNum = lostNum + LOSS_W'(lostMask[i]);
        end
        lostCnt_d = satAdd(lost_clr_i ? '0 : lostCnt_q, LOST_CNT_W'(lostNum));
    end

    // Pending bits and lost counter; reset drops everything silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            lostCnt_q <= '0;
        end else begin
            pending_q <= pending_d;
            lostCnt_q <= lostCnt_d;
        end
    end

    assign lost_cnt_o = lostCnt_q;

    udma_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ID_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pushEn),
        .pop_i   (popEn),
        .data_i  (selId),
        .data_o  (evt_id_o),
        .cnt_o   (fifo_cnt_o),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

endmodule

// File: tb/tb_udma_event_collector.sv
// Self-checking bench for udma_event_collector with default parameters.
// A queue-based reference model tracks pending lines, queued indices and the
// lost counter; each scenario task compares the DUT outputs against it.
module tb_udma_event_collector;

    localparam int NB    = 128;
    localparam int DEPTH = 8;

    logic         clk;
    logic         rst;
    logic [127:0] evt;
    logic [127:0] mask;
    logic         ready;
    logic         lostClr;
    logic         evt_valid_o;
    logic [6:0]   evt_id_o;
    logic [3:0]   fifo_cnt_o;
    logic [15:0]  lost_cnt_o;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model state.
    bit [127:0] mPend;
    int         mq[$];
    int         mLost;

    logic       expValid;
    logic [6:0] expId;
    logic [3:0] expCnt;
    logic [15:0] expLost;

    udma_event_collector #(
        .NB_EVT     (NB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .evt_i       (evt),
        .mask_i      (mask),
        .evt_valid_o (evt_valid_o),
        .evt_id_o    (evt_id_o),
        .evt_ready_i (ready),
        .fifo_cnt_o  (fifo_cnt_o),
        .lost_cnt_o  (lost_cnt_o),
        .lost_clr_i  (lostClr)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock edge of the behavioural model.
    function automatic void modelStep(input logic [127:0] e, input logic [127:0] m,
                                      input logic r, input logic c, input logic rs);
        int sel;
        int n;
        bit pop;
        if (rs) begin
            mPend = '0;
            mq.delete();
            mLost = 0;
            return;
        end
        pop = (mq.size() != 0) && r;
        sel = -1;
        for (int i = 0; i < NB; i++) begin
            if (mPend[i]) begin
                sel = i;
                break;
            end
        end
        if (pop) void'(mq.pop_front());
        if (sel >= 0 && ((mq.size() + (pop ? 1 : 0)) < DEPTH || pop)) begin
            mq.push_back(sel);
            mPend[sel] = 1'b0;
        end
        n = 0;
        for (int i = 0; i < NB; i++) begin
            if (e[i] && !m[i]) begin
                if (mPend[i]) n++;
                mPend[i] = 1'b1;
            end
        end
        mLost = (c ? 0 : mLost) + n;
        if (mLost > 65535) mLost = 65535;
    endfunction

    // Drives one cycle of inputs, advances the model and samples after the edge.
    task automatic applyStimulus(input logic [127:0] e, input logic [127:0] m,
                                 input logic r, input logic c, input logic rs);
        evt = e; mask = m; ready = r; lostClr = c; rst = rs;
        modelStep(e, m, r, c, rs);
        @(posedge clk);
        #1;
        expCnt   = 4'(mq.size());
        expValid = (mq.size() != 0);
        expId    = expValid ? 7'(mq[0]) : 7'd0;
        expLost  = 16'(mLost);
    endtask

    task automatic test_reset();
        applyStimulus('1, '0, 1'b0, 1'b0, 1'b1);
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
        nChecks++;
        if ({evt_valid_o, evt_id_o, fifo_cnt_o, lost_cnt_o} !== 28'h0) begin
            $display("[TB] FAIL reset_state got %h exp %h",
                     {evt_valid_o, evt_id_o, fifo_cnt_o, lost_cnt_o}, 28'h0);
        end else nPass++;
    endtask

    task automatic test_single_pulse();
        logic [127:0] e;
        e = '0; e[5] = 1'b1;
        applyStimulus(e, '0, 1'b1, 1'b0, 1'b0);
        nChecks++;
        if (evt_valid_o !== 1'b0) begin
            $display("[TB] FAIL single_early got %b exp 0", evt_valid_o);
        end else nPass++;
        applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
        nChecks++;
        if ({evt_valid_o, evt_id_o, lost_cnt_o} !== {1'b1, 7'd5, 16'd0}) begin
            $display("[TB] FAIL single_head got v%b id%0d lost%0d exp v1 id5 lost0",
                     evt_valid_o, evt_id_o, lost_cnt_o);
        end else nPass++;
        applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
        nChecks++;
        if ({evt_valid_o, fifo_cnt_o} !== {expValid, expCnt} || evt_valid_o !== 1'b0) begin
            $display("[TB] FAIL single_once got v%b cnt%0d exp v0 cnt0", evt_valid_o, fifo_cnt_o);
        end else nPass++;
    endtask

    task automatic test_multi_line();
        logic [127:0] e;
        int got[$];
        e = '0; e[3] = 1'b1; e[64] = 1'b1; e[127] = 1'b1;
        applyStimulus(e, '0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
            if (evt_valid_o) got.push_back(int'(evt_id_o));
            nChecks++;
            if ({evt_valid_o, evt_id_o, fifo_cnt_o} !== {expValid, expId, expCnt}) begin
                $display("[TB] FAIL multi_step%0d got %h exp %h", k,
                         {evt_valid_o, evt_id_o, fifo_cnt_o}, {expValid, expId, expCnt});
            end else nPass++;
        end
        nChecks++;
        if (got.size() != 3 || got[0] != 3 || got[1] != 64 || got[2] != 127) begin
            $display("[TB] FAIL multi_order got %p exp '{3,64,127}", got);
        end else nPass++;
    endtask

    task automatic test_fill_and_drain();
        logic [127:0] e;
        int got[$];
        for (int k = 0; k < 10; k++) begin
            e = '0; e[k] = 1'b1;
            applyStimulus(e, '0, 1'b0, 1'b0, 1'b0);
        end
        nChecks++;
        if ({fifo_cnt_o, evt_id_o} !== {4'd8, 7'd0} || fifo_cnt_o !== expCnt) begin
            $display("[TB] FAIL fill_full got cnt%0d head%0d exp cnt8 head0", fifo_cnt_o, evt_id_o);
        end else nPass++;
        for (int k = 0; k < 14; k++) begin
            if (evt_valid_o) got.push_back(int'(evt_id_o));
            applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
        end
        nChecks++;
        if (got.size() != 10) begin
            $display("[TB] FAIL drain_count got %0d exp 10", got.size());
        end else nPass++;
        for (int k = 0; k < got.size() && k < 10; k++) begin
            nChecks++;
            if (got[k] != k) begin
                $display("[TB] FAIL drain_order[%0d] got %0d exp %0d", k, got[k], k);
            end else nPass++;
        end
        nChecks++;
        if (lost_cnt_o !== 16'd0) begin
            $display("[TB] FAIL drain_lost got %0d exp 0", lost_cnt_o);
        end else nPass++;
    endtask

    task automatic test_loss_and_clear();
        logic [127:0] e;
        logic [127:0] e2;
        e = '0;
        for (int i = 30; i < 38; i++) e[i] = 1'b1;
        e2 = '0; e2[2] = 1'b1;
        applyStimulus(e, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(e2, '0, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if (lost_cnt_o !== 16'd2 || lost_cnt_o !== expLost) begin
            $display("[TB] FAIL loss_count got %0d exp 2", lost_cnt_o);
        end else nPass++;
        applyStimulus('0, '0, 1'b0, 1'b1, 1'b0);
        nChecks++;
        if (lost_cnt_o !== 16'd0) begin
            $display("[TB] FAIL loss_clear got %0d exp 0", lost_cnt_o);
        end else nPass++;
        for (int k = 0; k < 12; k++) applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
        nChecks++;
        if ({evt_valid_o, fifo_cnt_o, lost_cnt_o} !== {expValid, expCnt, expLost}) begin
            $display("[TB] FAIL loss_drain got %h exp %h",
                     {evt_valid_o, fifo_cnt_o, lost_cnt_o}, {expValid, expCnt, expLost});
        end else nPass++;
    endtask

    task automatic test_mask();
        logic [127:0] e;
        logic [127:0] e7;
        logic [127:0] m7;
        int seen;
        e7 = '0; e7[7] = 1'b1;
        m7 = e7;
        applyStimulus(e7, m7, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus('0, m7, 1'b1, 1'b0, 1'b0);
            nChecks++;
            if (evt_valid_o !== 1'b0) begin
                $display("[TB] FAIL mask_block%0d got v%b id%0d exp v0", k, evt_valid_o, evt_id_o);
            end else nPass++;
        end
        e = '0;
        for (int i = 30; i < 38; i++) e[i] = 1'b1;
        applyStimulus(e, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(e7, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(e7, m7, 1'b0, 1'b0, 1'b0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (evt_valid_o && evt_id_o == 7'd7) seen++;
            applyStimulus('0, m7, 1'b1, 1'b0, 1'b0);
        end
        nChecks++;
        if (seen != 1 || lost_cnt_o !== 16'd0) begin
            $display("[TB] FAIL mask_pending got seen%0d lost%0d exp seen1 lost0", seen, lost_cnt_o);
        end else nPass++;
    endtask

    task automatic test_reset_mid();
        logic [127:0] e;
        e = '0;
        for (int i = 20; i < 26; i++) e[i] = 1'b1;
        applyStimulus(e, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) applyStimulus('0, '0, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if (fifo_cnt_o !== 4'd4 || fifo_cnt_o !== expCnt) begin
            $display("[TB] FAIL mid_setup got cnt%0d exp 4", fifo_cnt_o);
        end else nPass++;
        applyStimulus('1, '0, 1'b1, 1'b0, 1'b1);
        nChecks++;
        if ({evt_valid_o, evt_id_o, fifo_cnt_o, lost_cnt_o} !== 28'h0) begin
            $display("[TB] FAIL mid_reset got %h exp %h",
                     {evt_valid_o, evt_id_o, fifo_cnt_o, lost_cnt_o}, 28'h0);
        end else nPass++;
        for (int k = 0; k < 4; k++) begin
            applyStimulus('0, '0, 1'b1, 1'b0, 1'b0);
            nChecks++;
            if (evt_valid_o !== 1'b0) begin
                $display("[TB] FAIL mid_stale%0d got v%b id%0d exp v0", k, evt_valid_o, evt_id_o);
            end else nPass++;
        end
    endtask

    task automatic test_saturation();
        for (int k = 0; k < 600; k++) applyStimulus('1, '0, 1'b0, 1'b0, 1'b0);
        nChecks++;
        if (lost_cnt_o !== 16'hFFFF || lost_cnt_o !== expLost) begin
            $display("[TB] FAIL sat_max got %h exp ffff", lost_cnt_o);
        end else nPass++;
        applyStimulus('1, '0, 1'b0, 1'b1, 1'b0);
        nChecks++;
        if (lost_cnt_o !== 16'd128) begin
            $display("[TB] FAIL sat_clear_keeps_new got %0d exp 128", lost_cnt_o);
        end else nPass++;
        applyStimulus('0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic [127:0] e;
        logic [127:0] m;
        logic r;
        logic c;
        for (int k = 0; k < 400; k++) begin
            e = '0; m = '0;
            for (int i = 0; i < 16; i++) begin
                if ($urandom_range(0, 5) == 0) e[i] = 1'b1;
                if ($urandom_range(0, 7) == 0) m[i] = 1'b1;
            end
            if ($urandom_range(0, 9) == 0) e[$urandom_range(16, 127)] = 1'b1;
            r = 1'($urandom_range(0, 1));
            c = ($urandom_range(0, 15) == 0);
            applyStimulus(e, m, r, c, 1'b0);
            nChecks++;
            if ({evt_valid_o, evt_id_o, fifo_cnt_o, lost_cnt_o} !== {expValid, expId, expCnt, expLost}) begin
                $display("[TB] FAIL random_cyc%0d got %h exp %h", k,
                         {evt_valid_o, evt_id_o, fifo_cnt_o, lost_cnt_o},
                         {expValid, expId, expCnt, expLost});
            end else nPass++;
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        rst = 1'b1; evt = '0; mask = '0; ready = 1'b0; lostClr = 1'b0;
        mPend = '0; mLost = 0;
        test_reset();
        test_single_pulse();
        test_multi_line();
        test_fill_and_drain();
        test_loss_and_clear();
        test_mask();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
